// File: rtl/mm_pkg.sv
// Shared definitions for the matrix operand fetch block: FSM states and FIFO depth.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/mm_operand_fifo.sv
// Two-entry FIFO holding aligned operand pairs plus their sideband tags.
// Simultaneous push and pop while full is accepted and leaves the count unchanged.
module mm_operand_fifo
  import mm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  // Control state: pointers and count are flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy qualifies it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/matrix_operand_fetch.sv
// Operand feeder for the matrix-multiply MAC: walks C = A*B in row/col/k order,
// reads A and B from synchronous memories and streams aligned pairs with op_last
// marking the final k of every dot product.
module matrix_operand_fetch
  import mm_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] matrix_a_addr,
  input  logic [ADDR_WIDTH-1:0] matrix_b_addr,
  input  logic [DIM_WIDTH-1:0]  N,
  input  logic [DIM_WIDTH-1:0]  M,
  input  logic [DIM_WIDTH-1:0]  P,
  output logic                  busy,
  output logic                  done,
  output logic                  dim_err,
  output logic                  mem_a_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_a_addr,
  input  logic [DATA_WIDTH-1:0] mem_a_rdata,
  output logic                  mem_b_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_b_addr,
  input  logic [DATA_WIDTH-1:0] mem_b_rdata,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  op_last,
  output logic [DIM_WIDTH-1:0]  op_row,
  output logic [DIM_WIDTH-1:0]  op_col
);

  localparam int PAY_W = 2*DATA_WIDTH + 1 + 2*DIM_WIDTH;
  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [DIM_WIDTH-1:0]    n_q, n_d, m_q, m_d, p_q, p_d;
  logic [DIM_WIDTH-1:0]    row_q, row_d, col_q, col_d, k_q, k_d;
  logic [ADDR_WIDTH-1:0]   b_base_q, b_base_d, row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0]   a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d;
  logic                    busy_q, busy_d, done_q, done_d, dim_err_q, dim_err_d;
  logic                    inflight_q, inflight_d;
  logic [2*DIM_WIDTH:0]    sb_q, sb_d;
  logic [1:0]              fifo_count;
  logic [PAY_W-1:0]        fifo_dout;
  logic                    pop, issue, credit_ok, drained, zero_dim;
  logic                    last_k, last_col, last_row;

  assign zero_dim  = (N == '0) || (M == '0) || (P == '0);
  assign last_k    = (k_q == m_q - DIM_ONE);
  assign last_col  = (col_q == p_q - DIM_ONE);
  assign last_row  = (row_q == n_q - DIM_ONE);
  assign op_valid  = (fifo_count != 2'd0);
  assign pop       = op_valid && op_ready;
  // A slot is reserved for every read already in flight, so the FIFO never overflows.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  assign issue     = (state_q == ST_ISSUE) && credit_ok;
  assign drained   = !inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

  assign mem_a_rd_en = issue;
  assign mem_b_rd_en = issue;
  assign mem_a_addr  = a_ptr_q;
  assign mem_b_addr  = b_ptr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dim_err     = dim_err_q;

  // FSM next state, index walk and incremental pointer arithmetic (no multipliers).
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    m_d        = m_q;
    p_d        = p_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    b_base_d   = b_base_q;
    row_base_d = row_base_q;
    a_ptr_d    = a_ptr_q;
    b_ptr_d    = b_ptr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dim_err_d  = 1'b0;
    inflight_d = issue;
    sb_d       = sb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (zero_dim) begin
            done_d    = 1'b1;
            dim_err_d = 1'b1;
          end else begin
            n_d        = N;
            m_d        = M;
            p_d        = P;
            b_base_d   = matrix_b_addr;
            row_base_d = matrix_a_addr;
            a_ptr_d    = matrix_a_addr;
            b_ptr_d    = matrix_b_addr;
            row_d      = '0;
            col_d      = '0;
            k_d        = '0;
            busy_d     = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          sb_d = {last_k, row_q, col_q};
          if (!last_k) begin
            k_d     = k_q + DIM_ONE;
            a_ptr_d = a_ptr_q + ADDR_ONE;
            b_ptr_d = b_ptr_q + ADDR_WIDTH'(p_q);
          end else if (!last_col) begin
            k_d     = '0;
            col_d   = col_q + DIM_ONE;
            a_ptr_d = row_base_q;
            b_ptr_d = b_base_q + ADDR_WIDTH'(col_q) + ADDR_ONE;
          end else begin
            k_d        = '0;
            col_d      = '0;
            row_d      = row_q + DIM_ONE;
            row_base_d = row_base_q + ADDR_WIDTH'(m_q);
            a_ptr_d    = row_base_q + ADDR_WIDTH'(m_q);
            b_ptr_d    = b_base_q;
            if (last_row) begin
              state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control, index and address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      m_q        <= '0;
      p_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      b_base_q   <= '0;
      row_base_q <= '0;
      a_ptr_q    <= '0;
      b_ptr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dim_err_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      m_q        <= m_d;
      p_q        <= p_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      b_base_q   <= b_base_d;
      row_base_q <= row_base_d;
      a_ptr_q    <= a_ptr_d;
      b_ptr_q    <= b_ptr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dim_err_q  <= dim_err_d;
      inflight_q <= inflight_d;
    end
  end

  // Sideband shadow of the read in flight; inflight_q qualifies it.
  always_ff @(posedge clk) begin
    sb_q <= sb_d;
  end

  mm_operand_fifo #(
    .WIDTH (PAY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   ({mem_a_rdata, mem_b_rdata, sb_q}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign {op_a, op_b, op_last, op_row, op_col} = fifo_dout;

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// Scoreboard bench for matrix_operand_fetch: a loop-nest reference model of
// C = A*B pushes expected pairs and read addresses; a monitor pops and compares.
module tb_matrix_operand_fetch;

  typedef logic [72:0] pair_t;   // {a, b, last, row, col}
  typedef logic [23:0] addr_t;   // {a_addr, b_addr}

  logic        clk = 1'b0;
  logic        rst, start, op_ready;
  logic [11:0] a_base, b_base;
  logic [3:0]  n_in, m_in, p_in;
  logic        busy, done, dim_err;
  logic        mem_a_rd_en, mem_b_rd_en;
  logic [11:0] mem_a_addr, mem_b_addr;
  logic [31:0] mem_a_rdata, mem_b_rdata;
  logic        op_valid, op_last;
  logic [31:0] op_a, op_b;
  logic [3:0]  op_row, op_col;

  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];

  pair_t exp_q[$];
  addr_t addr_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rd_cnt = 0, hs_cnt = 0, done_cnt = 0;
  int last_hs_cyc = 0, done_cyc = 0;
  logic done_err = 1'b0;
  int ready_mode = 0;
  int rcyc = 0;
  logic held_v = 1'b0;
  pair_t held;

  matrix_operand_fetch #(
    .ADDR_WIDTH (12),
    .DATA_WIDTH (32),
    .DIM_WIDTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .matrix_a_addr (a_base),
    .matrix_b_addr (b_base),
    .N             (n_in),
    .M             (m_in),
    .P             (p_in),
    .busy          (busy),
    .done          (done),
    .dim_err       (dim_err),
    .mem_a_rd_en   (mem_a_rd_en),
    .mem_a_addr    (mem_a_addr),
    .mem_a_rdata   (mem_a_rdata),
    .mem_b_rd_en   (mem_b_rd_en),
    .mem_b_addr    (mem_b_addr),
    .mem_b_rdata   (mem_b_rdata),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .op_last       (op_last),
    .op_row        (op_row),
    .op_col        (op_col)
  );

  always #5 clk = ~clk;

  // Synchronous operand memories: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_a_rd_en) mem_a_rdata <= mem_a[mem_a_addr];
    if (mem_b_rd_en) mem_b_rdata <= mem_b[mem_b_addr];
  end

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  // Monitor: checks read addresses, pairs, stall stability; records done pulses.
  always @(negedge clk) begin
    pair_t cur;
    pair_t ep;
    addr_t ea;
    cyc++;
    cur = {op_a, op_b, op_last, op_row, op_col};
    if (mem_a_rd_en || mem_b_rd_en) begin
      rd_cnt++;
      if (addr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got read a=%h b=%h required no read", mem_a_addr, mem_b_addr);
      end else begin
        ea = addr_q.pop_front();
        chk("rd_addr", {mem_a_rd_en, mem_b_rd_en, mem_a_addr, mem_b_addr}, {2'b11, ea});
      end
    end
    if (held_v) chk("stall_hold", {op_valid, cur}, {1'b1, held});
    held_v = op_valid && !op_ready && !rst;
    held   = cur;
    if (op_valid && op_ready) begin
      hs_cnt++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pair_unexpected: got %h required no pair", cur);
      end else begin
        ep = exp_q.pop_front();
        chk("pair", cur, ep);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = dim_err;
    end
  end

  // Consumer back-pressure patterns.
  initial begin
    op_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rcyc++;
      case (ready_mode)
        0: op_ready = 1'b1;
        1: op_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        2: op_ready = 1'($urandom_range(0, 1));
        default: op_ready = 1'b0;
      endcase
    end
  end

  // Reference model: C = A(NxM)*B(MxP) visited row, col, k ascending.
  task automatic model(input int n, input int m, input int p, input int ab, input int bb);
    int aa, ba;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++)
        for (int k = 0; k < m; k++) begin
          aa = (ab + i*m + k) % 4096;
          ba = (bb + k*p + j) % 4096;
          exp_q.push_back({mem_a[aa], mem_b[ba], (k == m-1), 4'(i), 4'(j)});
          addr_q.push_back({12'(aa), 12'(ba)});
        end
  endtask

  task automatic pulse_start(input int n, input int m, input int p, input int ab, input int bb);
    n_in = 4'(n); m_in = 4'(m); p_in = 4'(p);
    a_base = 12'(ab); b_base = 12'(bb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Inputs may change freely while busy.
    n_in = 4'($urandom); m_in = 4'($urandom); p_in = 4'($urandom);
    a_base = 12'($urandom); b_base = 12'($urandom);
  endtask

  task automatic run_mm(input int n, input int m, input int p, input int ab, input int bb,
                        input int mode, input bit poke);
    int lat, t, base_done, base_rd;
    bit nz;
    nz = (n != 0) && (m != 0) && (p != 0);
    ready_mode = mode;
    if (nz) model(n, m, p, ab, bb);
    base_done = done_cnt;
    base_rd   = rd_cnt;
    pulse_start(n, m, p, ab, bb);
    if (!nz) begin
      chk("zero_done", done, 1'b1);
      chk("zero_dim_err", dim_err, 1'b1);
      chk("zero_busy", busy, 1'b0);
      @(posedge clk); #1;
      chk("zero_done_pulse", done, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      chk("zero_no_reads", 96'(rd_cnt - base_rd), 96'(0));
      chk("zero_busy_after", busy, 1'b0);
      return;
    end
    chk("busy_after_start", busy, 1'b1);
    chk("no_done_at_start", done, 1'b0);
    lat = 1;
    while (!op_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_latency", 96'(lat), 96'(3));
    if (poke) begin
      pulse_start(1, 1, 1, 0, 0);
    end
    if (mode == 3) begin
      repeat (7) @(posedge clk);
      #1;
      n_cmp++;
      if (rd_cnt - base_rd > 2) begin
        n_bad++;
        $display("FAIL stall_reads: got %0d reads required at most 2", rd_cnt - base_rd);
      end
      chk("stall_fifo_holds", op_valid, 1'b1);
      ready_mode = 0;
    end
    t = 0;
    while (done_cnt == base_done && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == base_done) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles required done", t);
    end
    chk("done_lag", 96'(done_cyc - last_hs_cyc), 96'(1));
    chk("done_dim_err", done_err, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 96'(done_cnt - base_done), 96'(1));
    chk("pairs_left", 96'(exp_q.size()), 96'(0));
    chk("reads_left", 96'(addr_q.size()), 96'(0));
  endtask

  task automatic run_reset();
    int t, base_hs, base_done;
    ready_mode = 0;
    model(2, 2, 2, 12'h000, 12'h010);
    base_hs   = hs_cnt;
    base_done = done_cnt;
    pulse_start(2, 2, 2, 12'h000, 12'h010);
    t = 0;
    while (hs_cnt < base_hs + 3 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("reset_reached_pair3", 96'(hs_cnt >= base_hs + 3), 96'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_op_valid", op_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("reset_discard", op_valid, 1'b0);
    chk("reset_no_done", 96'(done_cnt - base_done), 96'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, p;
    rst = 1'b1; start = 1'b0;
    n_in = '0; m_in = '0; p_in = '0; a_base = '0; b_base = '0;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3; mem_a[3] = 32'd4;
    mem_b[16] = 32'd5; mem_b[17] = 32'd6; mem_b[18] = 32'd7; mem_b[19] = 32'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_dim_err", dim_err, 1'b0);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_rd_en", {mem_a_rd_en, mem_b_rd_en}, 2'b00);
    chk("rst_addrs", {mem_a_addr, mem_b_addr}, 24'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_mm(2, 2, 2, 12'h000, 12'h010, 0, 1'b0);   // directed 2x2x2, full throughput
    run_mm(2, 2, 2, 12'h000, 12'h010, 1, 1'b0);   // same, ready 1,0,0,1
    run_mm(1, 3, 1, 12'hFFE, 12'h100, 0, 1'b0);   // A address wrap
    run_mm(2, 0, 3, 12'h000, 12'h000, 0, 1'b0);   // zero dimension
    run_mm(2, 3, 2, 12'h200, 12'h300, 3, 1'b0);   // consumer stalled after start
    run_reset();
    run_mm(2, 2, 2, 12'h000, 12'h010, 0, 1'b0);   // clean run after reset
    run_mm(2, 15, 3, 12'hF80, 12'hFF0, 2, 1'b0);  // widest M, B wrap
    run_mm(3, 3, 3, 12'h400, 12'h500, 2, 1'b1);   // start poked while busy
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      m = $urandom_range(1, 4);
      p = $urandom_range(1, 4);
      run_mm(n, m, p, $urandom_range(0, 4095), $urandom_range(0, 4095), 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
